// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin merge of N read requesters onto one AXI AR/R port,
// one outstanding read at a time, with per-master error and protocol-fault flags.
module axi_rd_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int LINE_WORDS  = 8,
   parameter int ID_W        = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_rreq,
   input  logic [2*NUM_MASTERS-1:0]      m_rtype,
   input  logic [ADDR_W*NUM_MASTERS-1:0] m_raddr,
   output logic [NUM_MASTERS-1:0]        m_arready,
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   output logic [NUM_MASTERS-1:0]        m_rlast,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [NUM_MASTERS-1:0]        m_rerr,
   input  logic [NUM_MASTERS-1:0]        m_rready,
   output logic [ID_W-1:0]               arid,
   output logic [ADDR_W-1:0]             araddr,
   output logic [7:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   output logic                          arvalid,
   input  logic                          arready,
   input  logic [ID_W-1:0]               rid,
   input  logic [DATA_W-1:0]             rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast,
   input  logic                          rvalid,
   output logic                          rready,
   output logic                          proto_err
);
   localparam int MW  = $clog2(NUM_MASTERS);
   localparam int SZ  = $clog2(DATA_W / 8);
   localparam int OFF = $clog2(LINE_WORDS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] LMASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
   typedef enum logic [1:0] {IDLE, AR, R} state_t;
   state_t              state_q;
   logic [MW-1:0]       gnt_q, gnt_d, rr_q;
   logic [7:0]          cnt_q, arlen_q;
   logic [ID_W-1:0]     arid_q;
   logic [ADDR_W-1:0]   araddr_q, req_addr;
   logic [2:0]          arsize_q;
   logic [1:0]          arburst_q, typ;
   logic                arvalid_q, perr_q, found, in_r, hs, bad;
   logic [NUM_MASTERS-1:0] oh;
   // first requester at or after rr_q, cyclic
   always_comb begin
      found = 1'b0;
      gnt_d = rr_q;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && m_rreq[(int'(rr_q) + i) % NUM_MASTERS]) begin
            found = 1'b1;
            gnt_d = MW'((int'(rr_q) + i) % NUM_MASTERS);
         end
      end
   end
   assign typ      = m_rtype[2*int'(gnt_d) +: 2];
   assign req_addr = m_raddr[ADDR_W*int'(gnt_d) +: ADDR_W];
   assign oh       = NUM_MASTERS'(1) << gnt_q;
   assign in_r     = state_q == R;
   assign rready   = in_r & m_rready[gnt_q];
   assign hs       = rvalid & rready;
   assign bad      = (rid != arid_q) || ((cnt_q == arlen_q) != rlast);
   assign m_arready = {NUM_MASTERS{state_q == AR && arready}} & oh;
   assign m_rvalid  = {NUM_MASTERS{in_r & rvalid}} & oh;
   assign m_rlast   = {NUM_MASTERS{in_r & rlast}} & oh;
   assign m_rerr    = {NUM_MASTERS{in_r & rvalid & (|rresp)}} & oh;
   assign m_rdata   = in_r ? rdata : '0;
   assign arid      = arid_q;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = arsize_q;
   assign arburst   = arburst_q;
   assign arvalid   = arvalid_q;
   assign proto_err = perr_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         rr_q      <= '0;
         cnt_q     <= '0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= 2'b01;
         arvalid_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (found) begin
               gnt_q     <= gnt_d;
               rr_q      <= (gnt_d == MW'(NUM_MASTERS - 1)) ? '0 : gnt_d + MW'(1);
               arid_q    <= ID_W'(gnt_d);
               arlen_q   <= (&typ) ? 8'(LINE_WORDS - 1) : 8'd0;
               arsize_q  <= (&typ) ? 3'(SZ) : {1'b0, typ};
               araddr_q  <= (&typ) ? req_addr & LMASK : req_addr;
               arvalid_q <= 1'b1;
               state_q   <= AR;
            end
            AR: if (arready) begin
               arvalid_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= R;
            end
            R: if (hs) begin
               cnt_q <= cnt_q + 8'd1;
               if (bad) perr_q <= 1'b1;
               if (rlast) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
